// File: rtl/keccak_in_buffer_if.sv
// Message-in / block-out bundle of the Keccak input buffer.
// The buffer side uses the slave modport; the message source / permutation core side uses master.
interface keccak_in_buffer_if #(
  parameter int N          = 64,
  parameter int RATE_WORDS = 17
);
  logic [N-1:0]            din;
  logic                    din_valid;
  logic                    din_ready;
  logic                    din_last;
  logic [3:0]              din_len;
  logic [RATE_WORDS*N-1:0] blk_data;
  logic                    blk_valid;
  logic                    blk_ready;
  logic                    blk_last;

  modport master (
    output din, din_valid, din_last, din_len, blk_ready,
    input  din_ready, blk_data, blk_valid, blk_last
  );

  modport slave (
    input  din, din_valid, din_last, din_len, blk_ready,
    output din_ready, blk_data, blk_valid, blk_last
  );
endinterface

// File: rtl/keccak_in_buffer.sv
// Assembles N-bit message words into rate-sized blocks, applies Keccak multi-rate
// padding and hands complete blocks to the permutation core over valid/ready.
module keccak_in_buffer #(
  parameter int         N          = 64,
  parameter int         RATE_WORDS = 17,
  parameter logic [7:0] PAD_BYTE   = 8'h01
) (
  input logic               clk,
  input logic               rst,
  keccak_in_buffer_if.slave bus
);

  localparam int NB    = N / 8;
  localparam int TOTB  = RATE_WORDS * NB;
  localparam int BW    = RATE_WORDS * N;
  localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int P_W   = $clog2(TOTB + NB + 1);

  typedef enum logic [1:0] {FILL = 2'd0, FULL = 2'd1, EXTRA = 2'd2} state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [BW-1:0]    buf_r;
  logic             valid_r;
  logic             last_r;
  logic             pad_pend_r;

  logic [BW-1:0]    nxt_buf_s;
  logic             din_ready_s;
  logic             accept_s;
  logic [7:0]       len_s;
  logic [P_W-1:0]   pad_pos_s;
  logic             pad_fits_s;

  // Keep bytes below len, zero the rest of the word.
  function automatic logic [N-1:0] mask_word(input logic [N-1:0] word, input logic [7:0] len);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) begin
      if (8'(k) < len) m[8*k +: 8] = word[8*k +: 8];
      else             m[8*k +: 8] = 8'h00;
    end
    return m;
  endfunction

  // Pad start byte at pos, 0x80 OR-ed into the final byte of the rate.
  function automatic logic [BW-1:0] pad_block(input logic [BW-1:0] blk, input logic [P_W-1:0] pos);
    logic [BW-1:0] b;
    b               = blk;
    b[8*pos +: 8]   = PAD_BYTE;
    b[BW-1 -: 8]    = b[BW-1 -: 8] | 8'h80;
    return b;
  endfunction

  assign din_ready_s = (state_r == FILL) && !rst;
  assign accept_s    = bus.din_valid && din_ready_s;
  assign len_s       = ({4'h0, bus.din_len} > 8'(NB)) ? 8'(NB) : {4'h0, bus.din_len};
  assign pad_pos_s   = P_W'(idx_r) * P_W'(NB) + P_W'(len_s);
  // A full final word in the top lane leaves no room for padding: it goes in an extra block.
  assign pad_fits_s  = (pad_pos_s < P_W'(TOTB));

  assign bus.din_ready = din_ready_s;
  assign bus.blk_data  = buf_r;
  assign bus.blk_valid = valid_r;
  assign bus.blk_last  = last_r;

  // Next buffer contents: lane write on accept, padding on completion, clear on handoff.
  always_comb begin
    nxt_buf_s = buf_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          if (bus.din_last) begin
            nxt_buf_s[N*idx_r +: N] = mask_word(bus.din, len_s);
            if (pad_fits_s) nxt_buf_s = pad_block(nxt_buf_s, pad_pos_s);
            else            nxt_buf_s = nxt_buf_s;
          end else begin
            nxt_buf_s[N*idx_r +: N] = bus.din;
          end
        end else begin
          nxt_buf_s = buf_r;
        end
      end
      FULL: begin
        if (valid_r && bus.blk_ready) nxt_buf_s = '0;
        else                          nxt_buf_s = buf_r;
      end
      EXTRA:   nxt_buf_s = pad_block(buf_r, '0);
      default: nxt_buf_s = '0;
    endcase
  end

  // Framing FSM with registered block handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FILL;
      idx_r      <= '0;
      buf_r      <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      pad_pend_r <= 1'b0;
    end else begin
      buf_r <= nxt_buf_s;
      case (state_r)
        FILL: begin
          if (accept_s) begin
            if (bus.din_last) begin
              state_r    <= FULL;
              valid_r    <= 1'b1;
              last_r     <= pad_fits_s;
              pad_pend_r <= !pad_fits_s;
            end else begin
              idx_r <= idx_r + 1'b1;
              if (idx_r == IDX_W'(RATE_WORDS - 1)) begin
                state_r <= FULL;
                valid_r <= 1'b1;
                last_r  <= 1'b0;
              end else begin
                state_r <= FILL;
              end
            end
          end else begin
            state_r <= FILL;
          end
        end
        FULL: begin
          if (valid_r && bus.blk_ready) begin
            idx_r   <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            state_r <= pad_pend_r ? EXTRA : FILL;
          end else begin
            state_r <= FULL;
          end
        end
        EXTRA: begin
          pad_pend_r <= 1'b0;
          valid_r    <= 1'b1;
          last_r     <= 1'b1;
          state_r    <= FULL;
        end
        default: begin
          state_r <= FILL;
          idx_r   <= '0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_in_buffer.sv
// Randomized bench for keccak_in_buffer: message-level byte model plus directed literal checks.
module tb_keccak_in_buffer;

  localparam int N    = 64;
  localparam int RW   = 17;
  localparam int NB   = N / 8;
  localparam int TOTB = RW * NB;
  localparam int BW   = RW * N;

  logic clk;
  logic rst;
  int   rdy_mode;   // 0 random, 1 hold low, 2 hold high
  int   n_total;
  int   n_pass;

  keccak_in_buffer_if #(.N(N), .RATE_WORDS(RW)) bus ();

  keccak_in_buffer #(.N(N), .RATE_WORDS(RW), .PAD_BYTE(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.blk_ready = 1'($urandom_range(0, 1));
        1:       bus.blk_ready = 1'b0;
        default: bus.blk_ready = 1'b1;
      endcase
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int bad;
    n_total++;
    if (act === exp) n_pass++;
    else begin
      bad = 0;
      for (int i = RW - 1; i >= 0; i--)
        if (act[N*i +: N] !== exp[N*i +: N]) bad = i;
      $display("FAIL %s: lane %0d got %h expected %h", name, bad, act[N*bad +: N], exp[N*bad +: N]);
    end
  endfunction

  // ---------------- behavioural model: message bytes -> padded blocks ----------------
  logic [BW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [BW-1:0] cur_blk;
  int            ncur;
  bit            gap;

  function automatic void model_accept(input logic [N-1:0] w, input logic last, input logic [3:0] len);
    int nb;
    nb = last ? ((int'(len) > NB) ? NB : int'(len)) : NB;
    for (int k = 0; k < nb; k++) begin
      cur_blk[8*ncur +: 8] = w[8*k +: 8];
      ncur++;
    end
    if (ncur == TOTB) begin
      exp_q.push_back(cur_blk);
      exp_last_q.push_back(1'b0);
      cur_blk = '0;
      ncur    = 0;
    end
    if (last) begin
      cur_blk[8*ncur +: 8] = 8'h01;
      cur_blk[BW-1 -: 8]   = cur_blk[BW-1 -: 8] | 8'h80;
      exp_q.push_back(cur_blk);
      exp_last_q.push_back(1'b1);
      cur_blk = '0;
      ncur    = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("din_ready_in_reset", bus.din_ready, 1'b0);
      exp_q.delete();
      exp_last_q.delete();
      cur_blk = '0;
      ncur    = 0;
      gap     = 1'b0;
    end else begin
      chk("din_ready", bus.din_ready, exp_q.size() == 0);
      chk("blk_valid", bus.blk_valid, (exp_q.size() > 0) && !gap);
      if (bus.blk_valid && exp_q.size() > 0) begin
        chk_blk("blk_data", bus.blk_data, exp_q[0]);
        chk("blk_last", bus.blk_last, exp_last_q[0]);
      end
      gap = bus.blk_valid && bus.blk_ready;
      if (gap && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
      end
      if (bus.din_valid && bus.din_ready) begin
        if (bus.din_last)
          assert (bus.din_len <= 4'(NB)) else $error("illegal din_len %0d", bus.din_len);
        model_accept(bus.din, bus.din_last, bus.din_len);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [BW-1:0] pad_only();
    logic [BW-1:0] b;
    b            = '0;
    b[7:0]       = 8'h01;
    b[BW-1 -: 8] = 8'h80;
    return b;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic last, input logic [3:0] len);
    int g;
    bus.din       = w;
    bus.din_last  = last;
    bus.din_len   = len;
    bus.din_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.din_ready && g < 300);
    if (g >= 300) chk("din_accept_timeout", bus.din_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic send_msg(input int nfull, input int last_len, input bit gaps);
    for (int i = 0; i < nfull; i++) begin
      send_word(rnd_word(), 1'b0, 4'd0);
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    send_word(rnd_word(), 1'b1, 4'(last_len));
  endtask

  task automatic wait_blk(input string name, input bit need_last);
    int g;
    g = 0;
    while (!(bus.blk_valid && (bus.blk_last || !need_last)) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(name, bus.blk_valid, 1'b1);
  endtask

  task automatic drain();
    int g;
    rdy_mode = 2;
    g = 0;
    while ((exp_q.size() != 0 || bus.blk_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0]  w;
    logic [BW-1:0] e;
    n_total       = 0;
    n_pass        = 0;
    rdy_mode      = 1;
    rst           = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    bus.din_len   = 4'd0;
    cur_blk       = '0;
    ncur          = 0;
    gap           = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_blk_valid", bus.blk_valid, 1'b0);
    chk("reset_blk_last", bus.blk_last, 1'b0);
    chk("reset_din_ready", bus.din_ready, 1'b1);
    chk_blk("reset_blk_data", bus.blk_data, '0);
    @(posedge clk);
    #1;

    // three-word message, block held back
    send_word(64'h1111111111111111, 1'b0, 4'd0);
    send_word(64'h2222222222222222, 1'b0, 4'd0);
    send_word(64'h3333333333333333, 1'b1, 4'd8);
    chk("msg3_latency_valid", bus.blk_valid, 1'b1);
    chk("msg3_lane0", bus.blk_data[0 +: 64], 64'h1111111111111111);
    chk("msg3_lane2", bus.blk_data[128 +: 64], 64'h3333333333333333);
    chk("msg3_lane3", bus.blk_data[192 +: 64], 64'h0000000000000001);
    chk("msg3_lane16", bus.blk_data[1024 +: 64], 64'h8000000000000000);
    chk("msg3_last", bus.blk_last, 1'b1);

    // back-pressure: din held valid for 10 cycles while the block waits
    bus.din       = 64'hCAFEF00DDEADBEEF;
    bus.din_last  = 1'b1;
    bus.din_len   = 4'd8;
    bus.din_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_din_ready", bus.din_ready, 1'b0);
      chk("hold_lane0", bus.blk_data[0 +: 64], 64'h1111111111111111);
    end
    rdy_mode = 2;
    send_word(64'hCAFEF00DDEADBEEF, 1'b1, 4'd8);
    chk("held_word_lane0", bus.blk_data[0 +: 64], 64'hCAFEF00DDEADBEEF);
    chk("held_word_lane1", bus.blk_data[64 +: 64], 64'h0000000000000001);
    drain();

    // empty message
    rdy_mode = 1;
    idle(1);
    send_word(rnd_word(), 1'b1, 4'd0);
    chk_blk("empty_block", bus.blk_data, pad_only());
    chk("empty_last", bus.blk_last, 1'b1);
    drain();

    // 17 full words: data block, then an extra padding block
    rdy_mode = 1;
    idle(1);
    for (int i = 0; i < RW - 1; i++) send_word(rnd_word(), 1'b0, 4'd0);
    w = rnd_word();
    send_word(w, 1'b1, 4'd8);
    chk("full_block_last", bus.blk_last, 1'b0);
    chk("full_block_lane16", bus.blk_data[1024 +: 64], w);
    rdy_mode = 2;
    idle(1);
    wait_blk("extra_block_wait", 1'b1);
    chk_blk("extra_block", bus.blk_data, pad_only());
    drain();

    // pad start and final 0x80 coincide in the top byte
    rdy_mode = 1;
    idle(1);
    for (int i = 0; i < RW - 1; i++) send_word(rnd_word(), 1'b0, 4'd0);
    send_word(64'h00AABBCCDDEEFF11, 1'b1, 4'd7);
    chk("coincide_lane16", bus.blk_data[1024 +: 64], 64'h81AABBCCDDEEFF11);
    chk("coincide_last", bus.blk_last, 1'b1);
    drain();

    // reset while a block is presented
    rdy_mode = 1;
    idle(1);
    send_word(rnd_word(), 1'b1, 4'd8);
    chk("pre_reset_valid", bus.blk_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_full_valid", bus.blk_valid, 1'b0);

    // reset mid-fill at idx 5, then a short message must carry no stale lanes
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) send_word(rnd_word(), 1'b0, 4'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(64'h0123456789ABCDEF, 1'b1, 4'd3);
    e             = '0;
    e[63:0]       = 64'h0000000001ABCDEF;
    e[BW-1 -: 8]  = 8'h80;
    chk_blk("post_reset_block", bus.blk_data, e);
    drain();

    // randomized messages with random back-pressure and input gaps
    rdy_mode = 0;
    for (int m = 0; m < 40; m++) begin
      send_msg($urandom_range(0, 40), $urandom_range(0, 8), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
